// File: rtl/control_unit.sv
// control_unit: multicycle fetch/decode/execute sequencer for the 8-bit
// accumulator CPU. It issues strobes to the PC, memory, IR, accumulator and ALU,
// and it bounds every memory wait with a timeout that halts the CPU with a
// sticky fault.
module control_unit #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic [3:0] operand,
    input  logic       zero_flag,
    input  logic       carry_flag,
    input  logic       mem_ready,
    output logic [2:0] state,
    output logic       addr_sel,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       acc_load,
    output logic [1:0] acc_src,
    output logic [1:0] alu_op,
    output logic       halted,
    output logic       mem_error
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_LOAD_IR = 3'd2,
        S_DECODE  = 3'd3,
        S_MEM_RD  = 3'd4,
        S_EXEC    = 3'd5,
        S_MEM_WR  = 3'd6,
        S_HALT    = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_STA = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_AND = 4'h5,
        OP_OR  = 4'h6,
        OP_LDI = 4'h7,
        OP_JMP = 4'h8,
        OP_JZ  = 4'h9,
        OP_JC  = 4'hA,
        OP_HLT = 4'hF
    } opcode_t;

    // Last counter value before the timeout fires; only meaningful when enabled.
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     cur;
    state_t     nxt;
    logic [7:0] wait_cnt;
    logic       timeout;
    logic       unused_operand;

    // operand is consumed by the datapath; the sequencer never looks at it.
    assign unused_operand = ^operand;

    assign state   = cur;
    assign timeout = !mem_ready && (MEM_TIMEOUT != 0) && (wait_cnt == TMO_LAST);

    // Conditional jumps resolve combinationally in DECODE from the live flags.
    assign pc_load = (cur == S_DECODE) &&
                     ((opcode == OP_JMP) ||
                      ((opcode == OP_JZ) && zero_flag) ||
                      ((opcode == OP_JC) && carry_flag));

    // Next-state selection; a ready cycle always wins over the timeout.
    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:    nxt = S_FETCH;
            S_FETCH:   nxt = mem_ready ? S_LOAD_IR : (timeout ? S_HALT : S_FETCH);
            S_LOAD_IR: nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: nxt = S_MEM_RD;
                    OP_LDI:  nxt = S_EXEC;
                    OP_STA:  nxt = S_MEM_WR;
                    OP_HLT:  nxt = S_HALT;
                    default: nxt = S_FETCH;
                endcase
            end
            S_MEM_RD:  nxt = mem_ready ? S_EXEC  : (timeout ? S_HALT : S_MEM_RD);
            S_EXEC:    nxt = S_FETCH;
            S_MEM_WR:  nxt = mem_ready ? S_FETCH : (timeout ? S_HALT : S_MEM_WR);
            S_HALT:    nxt = S_HALT;
            default:   nxt = S_IDLE;
        endcase
    end

    // State, wait counter, fault flag and Moore outputs; outputs are registered
    // from the next state so they line up exactly with the state they decode.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur       <= S_IDLE;
            wait_cnt  <= '0;
            mem_error <= 1'b0;
            addr_sel  <= 1'b0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            ir_load   <= 1'b0;
            pc_inc    <= 1'b0;
            acc_load  <= 1'b0;
            acc_src   <= 2'b00;
            alu_op    <= 2'b00;
            halted    <= 1'b0;
        end else begin
            cur <= nxt;

            if (nxt != cur)
                wait_cnt <= '0;
            else if ((cur == S_FETCH) || (cur == S_MEM_RD) || (cur == S_MEM_WR))
                wait_cnt <= wait_cnt + 8'd1;

            if (((cur == S_FETCH) || (cur == S_MEM_RD) || (cur == S_MEM_WR)) && timeout)
                mem_error <= 1'b1;

            addr_sel  <= (nxt == S_MEM_RD) || (nxt == S_MEM_WR);
            mem_read  <= (nxt == S_FETCH)  || (nxt == S_MEM_RD);
            mem_write <= (nxt == S_MEM_WR);
            ir_load   <= (nxt == S_LOAD_IR);
            pc_inc    <= (nxt == S_LOAD_IR);
            acc_load  <= (nxt == S_EXEC);
            halted    <= (nxt == S_HALT);

            acc_src <= 2'b00;
            alu_op  <= 2'b00;
            if (nxt == S_EXEC) begin
                case (opcode)
                    OP_LDA:  acc_src <= 2'b01;
                    OP_LDI:  acc_src <= 2'b10;
                    OP_SUB:  alu_op  <= 2'b01;
                    OP_AND:  alu_op  <= 2'b10;
                    OP_OR:   alu_op  <= 2'b11;
                    default: alu_op  <= 2'b00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized instruction stream for control_unit, checked
// cycle by cycle against an instruction-level trace model.
module tb_control_unit;

    localparam int TMO = 15;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       zero_flag;
    logic       carry_flag;
    logic       mem_ready;
    logic [2:0] state;
    logic       addr_sel, mem_read, mem_write, ir_load, pc_inc, pc_load;
    logic       acc_load, halted, mem_error;
    logic [1:0] acc_src, alu_op;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit          rdy;
        logic [15:0] exp;
        bit          abort;
    } rec_t;

    rec_t q[$];

    control_unit #(.MEM_TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .operand(operand),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .mem_ready(mem_ready),
        .state(state), .addr_sel(addr_sel), .mem_read(mem_read),
        .mem_write(mem_write), .ir_load(ir_load), .pc_inc(pc_inc),
        .pc_load(pc_load), .acc_load(acc_load), .acc_src(acc_src),
        .alu_op(alu_op), .halted(halted), .mem_error(mem_error)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] observed();
        return {state, addr_sel, mem_read, mem_write, ir_load, pc_inc, pc_load,
                acc_load, acc_src, alu_op, halted, mem_error};
    endfunction

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One expected cycle: state, mem_ready to drive, and every output.
    function automatic void push(int st, bit rdy, bit asel, bit mr, bit mw, bit irl,
                                 bit pci, bit pcl, bit accl, int src, int aop,
                                 bit hlt, bit merr, bit ab = 1'b0);
        rec_t r;
        logic [2:0] s3;
        logic [1:0] s2, a2;
        s3 = 3'(st);
        s2 = 2'(src);
        a2 = 2'(aop);
        r.rdy   = rdy;
        r.abort = ab;
        r.exp   = {s3, asel, mr, mw, irl, pci, pcl, accl, s2, a2, hlt, merr};
        q.push_back(r);
    endfunction

    function automatic void halt_tail(bit merr);
        for (int i = 0; i < 3; i++)
            push(7, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, merr);
    endfunction

    // Memory wait: 'waits' not-ready cycles then a ready one, unless the
    // not-ready run reaches the timeout, in which case the CPU faults to HALT.
    function automatic bit wait_phase(int st, int waits, bit asel, bit mr, bit mw);
        for (int i = 0; i <= waits; i++) begin
            if (i == TMO) begin
                halt_tail(1'b1);
                return 1'b1;
            end
            push(st, i == waits, asel, mr, mw, 0, 0, 0, 0, 0, 0, 0, 0);
        end
        return 1'b0;
    endfunction

    // Expected trace of one instruction; returns 1 when a reset must follow.
    function automatic bit build(int op, bit zf, bit cf, int wf, int wm, bit ab);
        bit pcl;
        bit is_rd;
        q.delete();
        if (wait_phase(1, wf, 0, 1, 0)) return 1'b1;
        push(2, 1'($urandom_range(0, 1)), 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        pcl = (op == 8) || ((op == 9) && zf) || ((op == 10) && cf);
        push(3, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, pcl, 0, 0, 0, 0, 0);
        if (op == 15) begin
            halt_tail(1'b0);
            return 1'b1;
        end
        is_rd = (op == 1) || (op >= 3 && op <= 6);
        if (op == 2) begin
            if (ab) begin
                push(6, 1'b0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
                return 1'b1;
            end
            return wait_phase(6, wm, 1, 0, 1);
        end
        if (is_rd && wait_phase(4, wm, 1, 1, 0)) return 1'b1;
        if (is_rd || op == 7)
            push(5, 1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 0, 1,
                 (op == 1) ? 1 : ((op == 7) ? 2 : 0),
                 (op >= 3 && op <= 6) ? op - 3 : 0, 0, 0);
        return 1'b0;
    endfunction

    task automatic do_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        #3 check_eq("reset_outputs", 32'(observed()), 32'h0);
        @(posedge clock);
        #4 check_eq("reset_hold", 32'(observed()), 32'h0);
        @(posedge clock);
        #1 reset = 1'b1;
        #3 check_eq("idle_after_reset", 32'(observed()), 32'h0);
    endtask

    task automatic run_queue(int op, bit zf, bit cf);
        for (int i = 0; i < q.size(); i++) begin
            @(posedge clock);
            #1;
            if (i == 0) begin
                opcode     = 4'(op);
                operand    = 4'($urandom);
                zero_flag  = zf;
                carry_flag = cf;
            end
            mem_ready = q[i].rdy;
            #3 check_eq($sformatf("op%0h_cyc%0d_st%0d", op, i, q[i].exp[15:13]),
                        32'(observed()), 32'(q[i].exp));
            if (q[i].abort) begin
                #1 reset = 1'b0;
                #1 check_eq("abort_mem_write", 32'(mem_write), 32'h0);
                check_eq("abort_state", 32'(state), 32'h0);
            end
        end
    endtask

    task automatic run_instr(int op, bit zf, bit cf, int wf, int wm, bit ab);
        bit need_rst;
        need_rst = build(op, zf, cf, wf, wm, ab);
        run_queue(op, zf, cf);
        if (need_rst) do_reset();
    endtask

    function automatic int pick_wait();
        return ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, TMO));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset = 1'b0; opcode = '0; operand = '0;
        zero_flag = 1'b0; carry_flag = 1'b0; mem_ready = 1'b0;
        do_reset();

        for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 0, 0, 0);  // NOP stream
        run_instr(3, 0, 0, 0, 0, 0);                              // ADD
        run_instr(9, 1, 0, 0, 0, 0);                              // JZ taken
        run_instr(9, 0, 1, 0, 0, 0);                              // JZ not taken
        run_instr(10, 0, 1, 0, 0, 0);                             // JC taken
        run_instr(0, 0, 0, 3, 0, 0);                              // FETCH waits
        run_instr(1, 0, 0, 0, TMO - 1, 0);                        // ready on boundary
        run_instr(3, 0, 0, 0, TMO, 0);                            // MEM_RD timeout
        run_instr(2, 0, 0, 0, 0, 1);                              // reset in MEM_WR
        run_instr(2, 0, 0, 0, 2, 0);                              // STA with waits
        run_instr(7, 0, 0, 0, 0, 0);                              // LDI
        run_instr(15, 0, 0, 0, 0, 0);                             // HLT

        for (int i = 0; i < 250; i++)
            run_instr(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), pick_wait(), pick_wait(),
                      ($urandom_range(0, 19) == 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
